// File: rtl/z480_bpred_pkg.sv
// ----------------------------------------------------------------------------
// z480_bpred_pkg
//   Shared types for the Z480 P7 front-end branch predictor:
//     ctr2_t          2-bit saturating direction counter
//     CTR_SNT..CTR_ST counter encodings (strongly/weakly not-taken/taken)
//     bpred_state_e   table sweep FSM states
//     sat2_upd()      saturating counter step toward the resolved direction
// ----------------------------------------------------------------------------
package z480_bpred_pkg;

   typedef logic [1:0] ctr2_t;

   localparam ctr2_t CTR_SNT = 2'b00;
   localparam ctr2_t CTR_WNT = 2'b01;
   localparam ctr2_t CTR_WT  = 2'b10;
   localparam ctr2_t CTR_ST  = 2'b11;

   typedef enum logic {
      INIT,
      RUN
   } bpred_state_e;

   function automatic ctr2_t sat2_upd(ctr2_t ctr, logic taken);
      ctr2_t res;
      if (taken) res = (ctr == CTR_ST)  ? CTR_ST  : ctr2_t'(ctr + 2'd1);
      else       res = (ctr == CTR_SNT) ? CTR_SNT : ctr2_t'(ctr - 2'd1);
      return res;
   endfunction

endpackage

// File: rtl/fe_bpred_stats.sv
// ----------------------------------------------------------------------------
// fe_bpred_stats
//   Free-running 32-bit (wrapping) event counters for the BTB predictor.
//   Ports:
//     clk, rst_n      clock / asynchronous active-low reset
//     clr             synchronous clear of all counters (table flush)
//     run             table is in RUN this cycle (one lookup counted)
//     hit             lookup hit this cycle
//     upd_acc         training update accepted this cycle
//     upd_mispred     accepted update disagreed with the table prediction
//     stat_*          counter outputs
// ----------------------------------------------------------------------------
module fe_bpred_stats (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clr,
   input  logic        run,
   input  logic        hit,
   input  logic        upd_acc,
   input  logic        upd_mispred,
   output logic [31:0] stat_lookups,
   output logic [31:0] stat_hits,
   output logic [31:0] stat_updates,
   output logic [31:0] stat_mispred
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_lookups <= '0;
         stat_hits    <= '0;
         stat_updates <= '0;
         stat_mispred <= '0;
      end else if (clr) begin
         stat_lookups <= '0;
         stat_hits    <= '0;
         stat_updates <= '0;
         stat_mispred <= '0;
      end else begin
         if (run)                 stat_lookups <= stat_lookups + 32'd1;
         if (run && hit)          stat_hits    <= stat_hits + 32'd1;
         if (upd_acc)             stat_updates <= stat_updates + 32'd1;
         if (upd_acc && upd_mispred) stat_mispred <= stat_mispred + 32'd1;
      end
   end

endmodule

// File: rtl/fe_bpred_btb.sv
// ----------------------------------------------------------------------------
// fe_bpred_btb
//   Direct-mapped BTB with per-entry 2-bit saturating counters. Supplies the
//   next fetch PC combinationally from the current fetch PC and is trained
//   from the commit/redirect update channel. Falls back to pc+4/not-taken on
//   a miss and while the valid bits are being swept after reset or flush.
//   Ports:
//     clk, rst_n       clock / asynchronous active-low reset
//     flush            invalidate the whole table (restarts the init sweep)
//     pc               current fetch PC
//     predicted_pc     next fetch PC
//     predicted_taken  prediction is taken
//     pred_hit         valid tag match at the pc index
//     ready            table initialised; lookups and training active
//     upd_valid/upd_pc/upd_taken/upd_target   resolved-branch training port
//   Configuration:
//     FE_BPRED_STATS_EN  adds stat_lookups/stat_hits/stat_updates/stat_mispred
// ----------------------------------------------------------------------------
module fe_bpred_btb
   import z480_bpred_pkg::*;
#(
   parameter int unsigned ENTRIES  = 16,
   parameter int unsigned TAG_W    = 12,
   parameter int unsigned PC_W     = 64,
   parameter ctr2_t       CTR_INIT = CTR_WT
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic [PC_W-1:0] pc,
   output logic [PC_W-1:0] predicted_pc,
   output logic            predicted_taken,
   output logic            pred_hit,
   output logic            ready,
   input  logic            upd_valid,
   input  logic [PC_W-1:0] upd_pc,
   input  logic            upd_taken,
   input  logic [PC_W-1:0] upd_target
`ifdef FE_BPRED_STATS_EN
   ,
   output logic [31:0]     stat_lookups,
   output logic [31:0]     stat_hits,
   output logic [31:0]     stat_updates,
   output logic [31:0]     stat_mispred
`endif
);

   localparam int unsigned IDX_W = $clog2(ENTRIES);
   localparam int unsigned TAG_LO = IDX_W + 2;
   localparam int unsigned TAG_HI = TAG_W + IDX_W + 1;

   bpred_state_e     state, state_nxt;
   logic [IDX_W-1:0] ptr, ptr_nxt;

   logic [ENTRIES-1:0] valid;
   ctr2_t              ctr    [ENTRIES];
   logic [TAG_W-1:0]   tag_q  [ENTRIES];
   logic [PC_W-1:0]    target [ENTRIES];

   logic [IDX_W-1:0] idx, u_idx;
   logic [TAG_W-1:0] tag, u_tag;
   logic             u_hit, upd_acc;

   // ---------------- sweep FSM ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= INIT;
         ptr   <= '0;
      end else begin
         state <= state_nxt;
         ptr   <= ptr_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      case (state)
         INIT: begin
            if (flush) begin
               ptr_nxt = '0;
            end else begin
               ptr_nxt = ptr + 1'b1;
               if (ptr == IDX_W'(ENTRIES - 1)) state_nxt = RUN;
            end
         end
         RUN: begin
            if (flush) begin
               state_nxt = INIT;
               ptr_nxt   = '0;
            end
         end
         default: begin
            state_nxt = INIT;
            ptr_nxt   = '0;
         end
      endcase
   end

   assign ready = (state == RUN);

   // ---------------- lookup ----------------
   assign idx = pc[IDX_W+1:2];
   assign tag = pc[TAG_HI:TAG_LO];

   assign pred_hit        = ready && valid[idx] && (tag_q[idx] == tag);
   assign predicted_taken = pred_hit && ctr[idx][1];
   assign predicted_pc    = predicted_taken ? target[idx] : pc + PC_W'(4);

   // ---------------- training ----------------
   assign u_idx   = upd_pc[IDX_W+1:2];
   assign u_tag   = upd_pc[TAG_HI:TAG_LO];
   assign u_hit   = valid[u_idx] && (tag_q[u_idx] == u_tag);
   assign upd_acc = ready && upd_valid && !flush;

   // A RUN-state flush needs no immediate clear: ready drops next cycle and
   // the sweep invalidates every entry before ready returns.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= '0;
      end else if (state == INIT) begin
         valid[ptr] <= 1'b0;
      end else if (upd_acc && !u_hit && upd_taken) begin
         valid[u_idx] <= 1'b1;
      end
   end

   // Payload arrays carry no reset; valid gates every use.
   always_ff @(posedge clk) begin
      if (upd_acc) begin
         if (u_hit) begin
            ctr[u_idx] <= sat2_upd(ctr[u_idx], upd_taken);
            if (upd_taken) target[u_idx] <= upd_target;
         end else if (upd_taken) begin
            ctr[u_idx]    <= CTR_INIT;
            tag_q[u_idx]  <= u_tag;
            target[u_idx] <= upd_target;
         end
      end
   end

   logic unused_pc_bits;
   assign unused_pc_bits = &{1'b0, pc[1:0], upd_pc[1:0],
                             pc[PC_W-1:TAG_HI+1], upd_pc[PC_W-1:TAG_HI+1]};

`ifdef FE_BPRED_STATS_EN
   logic u_pred_taken, u_mispred;

   assign u_pred_taken = u_hit && ctr[u_idx][1];
   assign u_mispred    = (u_pred_taken != upd_taken) ||
                         (upd_taken && (target[u_idx] != upd_target));

   fe_bpred_stats u_stats (
      .clk          (clk),
      .rst_n        (rst_n),
      .clr          (flush),
      .run          (ready),
      .hit          (pred_hit),
      .upd_acc      (upd_acc),
      .upd_mispred  (u_mispred),
      .stat_lookups (stat_lookups),
      .stat_hits    (stat_hits),
      .stat_updates (stat_updates),
      .stat_mispred (stat_mispred)
   );
`endif

endmodule

// File: tb/tb_fe_bpred_btb.sv
// ----------------------------------------------------------------------------
// tb_fe_bpred_btb
//   Directed bench for fe_bpred_btb (ENTRIES=16, TAG_W=12, PC_W=64). The
//   driver issues one vector per cycle and queues its expected outputs; a
//   negedge monitor pops and compares against the DUT.
// ----------------------------------------------------------------------------
module tb_fe_bpred_btb;

   typedef struct packed {
      logic        ready;
      logic        hit;
      logic        taken;
      logic [63:0] ppc;
      logic        chk_stats;
      logic [31:0] lookups;
      logic [31:0] hits;
      logic [31:0] updates;
      logic [31:0] mispred;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic [63:0] pc;
   logic [63:0] predicted_pc;
   logic        predicted_taken;
   logic        pred_hit;
   logic        ready;
   logic        upd_valid;
   logic [63:0] upd_pc;
   logic        upd_taken;
   logic [63:0] upd_target;
`ifdef FE_BPRED_STATS_EN
   logic [31:0] stat_lookups, stat_hits, stat_updates, stat_mispred;
`endif

   exp_t  exp_q [$];
   string name_q [$];
   logic  chk     = 1'b0;
   logic  end_req = 1'b0;
   int    n_checks = 0;
   int    n_fail   = 0;

   // Stats expectation attached to the next issued vector.
   logic        st_en = 1'b0;
   logic [31:0] st_l = '0, st_h = '0, st_u = '0, st_m = '0;

   fe_bpred_btb #(
      .ENTRIES  (16),
      .TAG_W    (12),
      .PC_W     (64),
      .CTR_INIT (2'b10)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .flush           (flush),
      .pc              (pc),
      .predicted_pc    (predicted_pc),
      .predicted_taken (predicted_taken),
      .pred_hit        (pred_hit),
      .ready           (ready),
      .upd_valid       (upd_valid),
      .upd_pc          (upd_pc),
      .upd_taken       (upd_taken),
      .upd_target      (upd_target)
`ifdef FE_BPRED_STATS_EN
      ,
      .stat_lookups    (stat_lookups),
      .stat_hits       (stat_hits),
      .stat_updates    (stat_updates),
      .stat_mispred    (stat_mispred)
`endif
   );

   always #5 clk = ~clk;

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (chk) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL no_expectation: DUT output presented with empty scoreboard");
         end else begin
            exp_t  e;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            n_checks++;
            if (ready !== e.ready || pred_hit !== e.hit ||
                predicted_taken !== e.taken || predicted_pc !== e.ppc) begin
               n_fail++;
               $display("FAIL %s: got ready=%0b hit=%0b taken=%0b pc=%h, expected ready=%0b hit=%0b taken=%0b pc=%h",
                        nm, ready, pred_hit, predicted_taken, predicted_pc,
                        e.ready, e.hit, e.taken, e.ppc);
            end
`ifdef FE_BPRED_STATS_EN
            if (e.chk_stats) begin
               n_checks++;
               if (stat_lookups !== e.lookups || stat_hits !== e.hits ||
                   stat_updates !== e.updates || stat_mispred !== e.mispred) begin
                  n_fail++;
                  $display("FAIL %s_stats: got l=%0d h=%0d u=%0d m=%0d, expected l=%0d h=%0d u=%0d m=%0d",
                           nm, stat_lookups, stat_hits, stat_updates, stat_mispred,
                           e.lookups, e.hits, e.updates, e.mispred);
               end
            end
`endif
         end
      end
      if (end_req) begin
         n_checks++;
         if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d unchecked expectations, expected 0", exp_q.size());
         end
      end
   end

   // ---------------- driver ----------------
   task automatic step(input logic [63:0] p, input logic uv, input logic [63:0] up,
                       input logic ut, input logic [63:0] ug, input logic fl,
                       input logic er, input logic eh, input logic et,
                       input logic [63:0] ep, input string nm);
      exp_t e;
      pc         = p;
      upd_valid  = uv;
      upd_pc     = up;
      upd_taken  = ut;
      upd_target = ug;
      flush      = fl;
      e.ready     = er;
      e.hit       = eh;
      e.taken     = et;
      e.ppc       = ep;
      e.chk_stats = st_en;
      e.lookups   = st_l;
      e.hits      = st_h;
      e.updates   = st_u;
      e.mispred   = st_m;
      exp_q.push_back(e);
      name_q.push_back(nm);
      st_en = 1'b0;
      chk   = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic look(input logic [63:0] p, input logic er, input logic eh,
                       input logic et, input logic [63:0] ep, input string nm);
      step(p, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, er, eh, et, ep, nm);
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; pc = '0;
      upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
      @(posedge clk);
      #1;

      look(64'h1000, 0, 0, 0, 64'h1004, "in_reset0");
      look(64'h1000, 0, 0, 0, 64'h1004, "in_reset1");
      rst_n = 1'b1;

      // Updates offered during the sweep must be dropped.
      for (int i = 0; i < 16; i++)
         step(64'h1000, 1, 64'h1000, 1, 64'h2000, 0, 0, 0, 0, 64'h1004, "init_sweep");

      step(64'h1000, 1, 64'h1000, 1, 64'h2000, 0, 1, 0, 0, 64'h1004, "run_first");
      look(64'h1000, 1, 1, 1, 64'h2000, "alloc_hit");
      step(64'h1000, 1, 64'h1000, 0, 64'h0, 0, 1, 1, 1, 64'h2000, "nt1_sees_old");
      step(64'h1000, 1, 64'h1000, 0, 64'h0, 0, 1, 1, 0, 64'h1004, "nt2_wnt");
      step(64'h1000, 1, 64'h1000, 0, 64'h0, 0, 1, 1, 0, 64'h1004, "nt3_snt");
      step(64'h1000, 1, 64'h1000, 1, 64'h2400, 0, 1, 1, 0, 64'h1004, "snt_held");
      step(64'h1000, 1, 64'h1000, 1, 64'h2400, 0, 1, 1, 0, 64'h1004, "wnt_up");
      step(64'h1000, 1, 64'h1000, 1, 64'h2400, 0, 1, 1, 1, 64'h2400, "wt_new_target");
      step(64'h1000, 1, 64'h1000, 1, 64'h2400, 0, 1, 1, 1, 64'h2400, "st_reached");
      step(64'h1000, 1, 64'h1000, 0, 64'h0, 0, 1, 1, 1, 64'h2400, "st_held");
      step(64'h1000, 1, 64'h1000, 0, 64'h0, 0, 1, 1, 1, 64'h2400, "wt_after_dec");
      look(64'h1000, 1, 1, 0, 64'h1004, "wnt_after_dec");
      look(64'h1004, 1, 0, 0, 64'h1008, "other_idx_miss");

      step(64'h1000, 1, 64'h1040, 1, 64'h3000, 0, 1, 1, 0, 64'h1004, "alias_upd");
      look(64'h1000, 1, 0, 0, 64'h1004, "alias_evicted");
      look(64'h1040, 1, 1, 1, 64'h3000, "alias_hit");
      look(64'hFFFF_FFFF_FFFF_FFFC, 1, 0, 0, 64'h0, "pc_wrap");
      step(64'h1040, 1, 64'h2008, 0, 64'h0, 0, 1, 1, 1, 64'h3000, "nt_miss_upd");
      look(64'h2008, 1, 0, 0, 64'h200C, "nt_no_alloc");

      // Flush in RUN with a live update, then a second flush mid-sweep.
      step(64'h1040, 1, 64'h1004, 1, 64'h5000, 1, 1, 1, 1, 64'h3000, "flush_cycle");
      for (int i = 0; i < 5; i++)
         look(64'h1040, 0, 0, 0, 64'h1044, "flush_sweep");
      step(64'h1040, 0, 64'h0, 0, 64'h0, 1, 0, 0, 0, 64'h1044, "flush_in_init");
      for (int i = 0; i < 16; i++)
         look(64'h1040, 0, 0, 0, 64'h1044, "resweep");

      // Three RUN lookups, one hit, one mispredicting update.
      step(64'h1040, 1, 64'h1000, 1, 64'h2000, 0, 1, 0, 0, 64'h1044, "post_flush_miss");
      look(64'h1000, 1, 1, 1, 64'h2000, "post_flush_alloc");
      look(64'h1004, 1, 0, 0, 64'h1008, "flushed_upd_dropped");
      st_en = 1'b1; st_l = 32'd3; st_h = 32'd1; st_u = 32'd1; st_m = 32'd1;
      look(64'h1040, 1, 0, 0, 64'h1044, "stats_point");

      chk     = 1'b0;
      end_req = 1'b1;
      @(negedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
